// File: rtl/tt_pkg.sv
// Shared types and sizes for the truth-table capture/compare checker.
package tt_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int TT_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } tt_state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Per-vector settle counter: counts 0..SETTLE_CYCLES-1 while enabled and
// flags the last cycle so the top can sample the DUT output on that edge.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("tt_settle_timer: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expire = enable && (count_q == LAST);

    // Next count: restart on clear, wrap to zero after the last settle cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive 4-input stimulus generator with truth-table capture and compare.
// Steps vectors 0..15, samples dut_out at the end of each settle window,
// and reports pass / first mismatching vector when the sweep completes.
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    input  logic            dut_out,
    output logic            a,
    output logic            b,
    output logic            c,
    output logic            d,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TT_W-1:0] captured,
    output logic            fail_valid,
    output logic [VEC_W-1:0] first_fail
);

    tt_state_e        state_q,      state_d;
    logic [VEC_W-1:0] idx_q,        idx_d;
    logic [TT_W-1:0]  exp_q,        exp_d;
    logic [TT_W-1:0]  captured_q,   captured_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic             pass_q,       pass_d;
    logic             fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0] first_fail_q, first_fail_d;

    logic             timer_clear;
    logic             timer_enable;
    logic             sample_now;
    logic [TT_W-1:0]  sample_mask;
    logic [TT_W-1:0]  captured_with_sample;

    assign timer_clear  = (state_q == IDLE) && start;
    assign timer_enable = (state_q == SETTLE);

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (sample_now)
    );

    // One-hot mask selecting the table bit of the vector currently held.
    genvar gi;
    generate
        for (gi = 0; gi < TT_W; gi++) begin : g_sample_bit
            assign sample_mask[gi] = (idx_q == VEC_W'(gi));
            assign captured_with_sample[gi] = sample_mask[gi] ? dut_out : captured_q[gi];
        end
    endgenerate

    // Sweep control: accept, capture/compare per vector, and completion.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        exp_d        = exp_q;
        captured_d   = captured_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SETTLE;
                    exp_d        = expected;
                    captured_d   = '0;
                    pass_d       = 1'b0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    idx_d        = '0;
                    busy_d       = 1'b1;
                end
            end
            SETTLE: begin
                if (sample_now) begin
                    captured_d = captured_with_sample;
                    // Only the first mismatch is recorded; later ones keep it.
                    if ((dut_out != exp_q[idx_q]) && !fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        first_fail_d = idx_q;
                    end
                    if (idx_q == VEC_W'(NUM_VECTORS - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (captured_with_sample == exp_q);
                    end else begin
                        idx_d = idx_q + VEC_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            exp_q        <= '0;
            captured_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            exp_q        <= exp_d;
            captured_q   <= captured_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign captured     = captured_q;
    assign fail_valid   = fail_valid_q;
    assign first_fail   = first_fail_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: two checker instances (settle 4 and settle 1) driving
// a behavioural model DUT, compared against a table-level reference model.
module tb_truth_table_checker;

    localparam int S4 = 4;
    localparam int S1 = 1;

    localparam int M_AND   = 0;
    localparam int M_OR    = 1;
    localparam int M_ZERO  = 2;
    localparam int M_PASSA = 3;
    localparam int M_TABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start4 = 1'b0, start1 = 1'b0;
    logic [15:0] expected4 = '0, expected1 = '0;
    logic        dut_out4, dut_out1;
    logic        a4, b4, c4, d4, a1, b1, c1, d1;
    logic        busy4, done4, pass4, fv4, busy1, done1, pass1, fv1;
    logic [15:0] cap4, cap1;
    logic [3:0]  ff4, ff1;

    int mode4 = M_AND, mode1 = M_PASSA;
    logic [15:0] tbl4 = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    truth_table_checker #(.SETTLE_CYCLES(S4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .expected(expected4), .dut_out(dut_out4),
        .a(a4), .b(b4), .c(c4), .d(d4), .busy(busy4), .done(done4), .pass(pass4),
        .captured(cap4), .fail_valid(fv4), .first_fail(ff4)
    );

    truth_table_checker #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expected1), .dut_out(dut_out1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .fail_valid(fv1), .first_fail(ff1)
    );

    // Behavioural logic function under test, selected by mode.
    function automatic logic model_fn(input int mode, input logic [15:0] tbl, input logic [3:0] v);
        case (mode)
            M_AND:   return &v;
            M_OR:    return |v;
            M_ZERO:  return 1'b0;
            M_PASSA: return v[3];
            default: return tbl[v];
        endcase
    endfunction

    always_comb dut_out4 = model_fn(mode4, tbl4, {a4, b4, c4, d4});
    always_comb dut_out1 = model_fn(mode1, 16'h0000, {a1, b1, c1, d1});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if ({a4, b4, c4, d4, busy4, done4, pass4, fv4, ff4, cap4} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: got %0h expected 0",
                     {a4, b4, c4, d4, busy4, done4, pass4, fv4, ff4, cap4});
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs idle at zero");
    endtask

    // One full sweep on the settle-4 instance with full timing checks.
    task automatic run4(input string name, input int mode, input logic [15:0] tbl,
                        input logic [15:0] exp, input bit repulse);
        logic [15:0] ref_cap;
        logic        ref_fv;
        logic [3:0]  ref_ff;
        int          errs_before;
        errs_before = n_errors;
        ref_cap = '0; ref_fv = 1'b0; ref_ff = '0;
        for (int i = 0; i < 16; i++) begin
            ref_cap[i] = model_fn(mode, tbl, 4'(i));
            if (ref_cap[i] != exp[i] && !ref_fv) begin
                ref_fv = 1'b1;
                ref_ff = 4'(i);
            end
        end
        mode4 = mode; tbl4 = tbl;
        start4 = 1'b1; expected4 = exp;
        tick();
        start4 = 1'b0;
        expected4 = ~exp;   // post-accept changes must be ignored
        chk({name, "_accept_clear"}, {pass4, fv4, cap4}, '0);
        for (int k = 0; k <= 16 * S4 + 1; k++) begin
            if (k > 0) tick();
            start4 = repulse && (k == 9 || k == 30 || k == 16 * S4);
            if (k < 16 * S4) begin
                n_checks++;
                if ({a4, b4, c4, d4} !== 4'(k / S4) || done4 !== 1'b0 || busy4 !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s_cycle%0d: vec=%0d done=%b busy=%b expected vec=%0d done=0 busy=1",
                             name, k, {a4, b4, c4, d4}, done4, busy4, k / S4);
                end
            end else if (k == 16 * S4) begin
                chk({name, "_done"}, {31'd0, done4}, 32'd1);
                chk({name, "_busy_in_done"}, {31'd0, busy4}, 32'd1);
                chk({name, "_captured"}, {16'd0, cap4}, {16'd0, ref_cap});
                chk({name, "_pass"}, {31'd0, pass4}, {31'd0, ref_cap == exp});
                chk({name, "_fail_valid"}, {31'd0, fv4}, {31'd0, ref_fv});
                if (ref_fv) chk({name, "_first_fail"}, {28'd0, ff4}, {28'd0, ref_ff});
            end else begin
                chk({name, "_idle_after"}, {26'd0, done4, busy4, a4, b4, c4, d4}, '0);
            end
        end
        start4 = 1'b0;
        tick();
        chk({name, "_pass_held"}, {31'd0, pass4}, {31'd0, ref_cap == exp});
        chk({name, "_still_idle"}, {31'd0, busy4}, 32'd0);
        $display("%s: mode=%0d exp=%04h captured=%04h pass=%b fv=%b ff=%0d %s", name, mode, exp,
                 cap4, pass4, fv4, ff4, (n_errors == errs_before) ? "ok" : "bad");
    endtask

    task automatic test_and();         run4("and",   M_AND,  '0, 16'h8000, 1'b0); endtask
    task automatic test_or();          run4("or",    M_OR,   '0, 16'h8000, 1'b0); endtask
    task automatic test_stuck_zero();  run4("stuck0", M_ZERO, '0, 16'hFFFF, 1'b0); endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [15:0] tb_tbl, tb_exp;
            tb_tbl = 16'($urandom);
            tb_exp = (t % 2 == 0) ? tb_tbl : 16'($urandom);
            run4($sformatf("rand%0d", t), M_TABLE, tb_tbl, tb_exp, 1'b0);
        end
    endtask

    task automatic test_repulse();
        run4("repulse", M_TABLE, 16'h5A3C, 16'h5A1C, 1'b1);
    endtask

    // Settle-1 instance: one vector per cycle, passthrough of a.
    task automatic test_vector_sequence();
        start1 = 1'b1; expected1 = 16'hFF00;
        tick();
        start1 = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick();
            if (k < 16) begin
                n_checks++;
                if ({a1, b1, c1, d1} !== 4'(k) || done1 !== 1'b0) begin
                    n_errors++;
                    $display("FAIL seq_cycle%0d: vec=%0d done=%b expected vec=%0d done=0",
                             k, {a1, b1, c1, d1}, done1, k);
                end
            end else begin
                chk("seq_done", {31'd0, done1}, 32'd1);
                chk("seq_captured", {16'd0, cap1}, 32'h0000FF00);
                chk("seq_pass", {30'd0, pass1, fv1}, 32'd2);
            end
        end
        tick();
        $display("sequence: S=1 captured=%04h pass=%b", cap1, pass1);
    endtask

    // Reset at vector 7 aborts with no done pulse; a fresh run then completes.
    task automatic test_reset_mid_run();
        int  budget;
        bit  saw_done;
        mode4 = M_OR;
        start4 = 1'b1; expected4 = 16'hFFFE;
        tick();
        start4 = 1'b0;
        budget = 0;
        while ({a4, b4, c4, d4} != 4'd7 && budget < 200) begin
            tick();
            budget++;
        end
        chk("rst_reach_vec7", {31'd0, budget < 200}, 32'd1);
        rst = 1'b1;
        start4 = 1'b1;   // reset wins over start
        tick();
        start4 = 1'b0;
        rst = 1'b0;
        chk("rst_mid_outputs", {a4, b4, c4, d4, busy4, done4, pass4, fv4, ff4, cap4}, '0);
        saw_done = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (done4 || busy4) saw_done = 1'b1;
        end
        chk("rst_no_done", {31'd0, saw_done}, 32'd0);
        $display("reset_mid_run: aborted at vector 7, no done");
        run4("after_rst", M_OR, '0, 16'hFFFE, 1'b0);
    endtask

    initial begin
        test_reset();
        test_and();
        test_or();
        test_stuck_zero();
        test_vector_sequence();
        test_random();
        test_repulse();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
